// File: rtl/apb_fll_pkg.sv
// apb_fll_pkg: shared state encoding and field layout for the multi-channel APB-to-FLL bridge.
package apb_fll_pkg;
  typedef enum logic [2:0] {IDLE, REQ, REL, RESP, ERR, ERR_TO, DRAIN} apb_fll_state_e;
  localparam int FLL_DATA_W = 32;
  localparam int FLL_ADD_W = 2;
  localparam int FLL_REG_LSB = 3;
  localparam int FLL_CH_LSB = 5;
endpackage

// File: rtl/fll_ack_sync.sv
// fll_ack_sync: two-flop synchroniser bringing one asynchronous FLL ack into the HCLK domain.
module fll_ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/apb_fll_if_multi.sv
// apb_fll_if_multi: APB slave driving NB_FLL FLL config ports over 4-phase req/ack handshakes.
// Define APB_FLL_IF_TIMEOUT_EN to build the REQ ack timeout with its ERR_TO/DRAIN recovery.
module apb_fll_if_multi
  import apb_fll_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_FLL = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CH_W = NB_FLL > 1 ? $clog2(NB_FLL) : 1
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [APB_ADDR_WIDTH-1:0]  PADDR,
  input  logic [31:0]                PWDATA,
  input  logic                       PWRITE,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  output logic [31:0]                PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NB_FLL-1:0]          fll_req,
  output logic [NB_FLL-1:0]          fll_wrn,
  output logic [NB_FLL*2-1:0]        fll_add,
  output logic [NB_FLL*32-1:0]       fll_data,
  input  logic [NB_FLL-1:0]          fll_ack,
  input  logic [NB_FLL*32-1:0]       fll_r_data
);
  apb_fll_state_e state, state_d;
  logic [CH_W-1:0] ch_q;
  logic [FLL_ADD_W-1:0] add_q;
  logic wrn_q;
  logic [FLL_DATA_W-1:0] data_q, rdata_q;
  logic [NB_FLL-1:0] ack_s;
  logic [CH_W:0] ch_idx;
  logic apb_go, ch_ok, ack_cur;
  logic unused_ok;
  assign unused_ok = ^{PADDR[FLL_REG_LSB-1:0], PADDR[APB_ADDR_WIDTH-1:FLL_CH_LSB+CH_W], TIMEOUT_CYCLES >= 4};
  for (genvar i = 0; i < NB_FLL; i++) begin : g_sync
    fll_ack_sync u_sync (.clk(HCLK), .rst(HRESET), .d(fll_ack[i]), .q(ack_s[i]));
  end
  // Zero-extended index so the range test stays meaningful when NB_FLL is a power of two.
  assign ch_idx = {1'b0, PADDR[FLL_CH_LSB +: CH_W]};
  assign ch_ok = ch_idx < (CH_W+1)'(NB_FLL);
  assign apb_go = PSEL & PENABLE;
  assign ack_cur = ack_s[ch_q];
`ifdef APB_FLL_IF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;
  logic to_hit;
  assign to_hit = timer == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge HCLK)
    if (HRESET || state != REQ) timer <= '0;
    else timer <= timer + 1'b1;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (apb_go) state_d = ch_ok ? REQ : ERR;
      REQ: begin
        if (ack_cur) state_d = REL;
`ifdef APB_FLL_IF_TIMEOUT_EN
        else if (to_hit) state_d = ERR_TO;
`endif
      end
      REL: if (!ack_cur) state_d = RESP;
`ifdef APB_FLL_IF_TIMEOUT_EN
      ERR_TO: state_d = DRAIN;
      DRAIN: if (!ack_cur) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state <= IDLE;
      ch_q <= '0;
      add_q <= '0;
      wrn_q <= 1'b0;
      data_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && apb_go && ch_ok) begin
        ch_q <= PADDR[FLL_CH_LSB +: CH_W];
        add_q <= PADDR[FLL_REG_LSB +: FLL_ADD_W];
        wrn_q <= ~PWRITE;
        data_q <= PWDATA;
      end
      if (state == REQ && ack_cur) rdata_q <= wrn_q ? fll_r_data[ch_q*FLL_DATA_W +: FLL_DATA_W] : '0;
    end
  always_comb begin
    fll_req = '0;
    fll_wrn = '0;
    fll_add = '0;
    fll_data = '0;
    for (int i = 0; i < NB_FLL; i++) begin
      fll_req[i] = state == REQ && ch_q == CH_W'(i);
      fll_wrn[i] = fll_req[i] & wrn_q;
      fll_add[i*FLL_ADD_W +: FLL_ADD_W] = fll_req[i] ? add_q : '0;
      fll_data[i*FLL_DATA_W +: FLL_DATA_W] = fll_req[i] ? data_q : '0;
    end
  end
  assign PREADY = state == RESP || state == ERR || state == ERR_TO;
  assign PSLVERR = state == ERR || state == ERR_TO;
  assign PRDATA = state == RESP ? rdata_q : '0;
endmodule
